image_param_ctrl: RTL and testbench

Key-driven parameter controller for the image-processing path. Consumes the one-cycle press pulses produced by the per-key debounce stages (mode, increment, decrement) and maintains a processing-mode selector and an 8-bit threshold. Detects double presses for coarse stepping. Commits new values to the pipeline only on the rising edge of frame vsync, so a frame is never processed with mixed settings.

---
 rtl/image_param_ctrl.sv | 153 +++++++++++++++
 tb/tb_image_param_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/image_param_ctrl.sv
// image_param_ctrl: key-driven mode/threshold controller with double-press coarse stepping and vsync-aligned commit.
// Optional build macro IMAGE_PARAM_WRAP_EN: threshold wraps modulo 256 instead of saturating.
`default_nettype none

module image_param_ctrl #(
  parameter int MODE_NUM   = 4,
  parameter int THR_INIT   = 128,
  parameter int THR_STEP   = 8,
  parameter int FAST_STEP  = 32,
  parameter int DBL_WINDOW = 16_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic       frame_vsync,
  output logic [1:0] proc_mode,
  output logic [7:0] threshold,
  output logic       param_update
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WIN_INC = 2'd1,
    ST_WIN_DEC = 2'd2
  } state_e;

  localparam logic [7:0]  c_thr_init  = 8'(THR_INIT);
  localparam logic [7:0]  c_fine_step = 8'(THR_STEP);
  localparam logic [7:0]  c_fast_step = 8'(FAST_STEP);
  localparam logic [1:0]  c_mode_last = 2'(MODE_NUM - 1);
  localparam logic [31:0] c_win_last  = 32'(DBL_WINDOW - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  sh_mode_q, sh_mode_d;
  logic [7:0]  sh_thr_q, sh_thr_d;
  logic        dirty_q, dirty_d;
  logic        vs_q;
  logic [1:0]  proc_mode_q;
  logic [7:0]  threshold_q;
  logic        param_update_q;

  logic w_inc_only, w_dec_only, w_key_hit, w_rise, w_commit;

  function automatic logic [7:0] thr_add(input logic [7:0] v, input logic [7:0] s);
`ifdef IMAGE_PARAM_WRAP_EN
    return v + s;
`else
    logic [8:0] sum;
    sum = {1'b0, v} + {1'b0, s};
    return sum[8] ? 8'hFF : sum[7:0];
`endif
  endfunction

  function automatic logic [7:0] thr_sub(input logic [7:0] v, input logic [7:0] s);
`ifdef IMAGE_PARAM_WRAP_EN
    return v - s;
`else
    logic [8:0] diff;
    diff = {1'b0, v} - {1'b0, s};
    return diff[8] ? 8'h00 : diff[7:0];
`endif
  endfunction

  // key_mode outranks inc/dec; simultaneous inc+dec is ignored entirely.
  assign w_inc_only = key_inc & ~key_dec & ~key_mode;
  assign w_dec_only = key_dec & ~key_inc & ~key_mode;
  assign w_rise     = frame_vsync & ~vs_q;
  assign w_commit   = w_rise & dirty_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_mode_d = sh_mode_q;
    sh_thr_d  = sh_thr_q;
    w_key_hit = 1'b0;
    if (key_mode) begin
      w_key_hit = 1'b1;
      sh_mode_d = (sh_mode_q == c_mode_last) ? 2'd0 : 2'(sh_mode_q + 2'd1);
      state_d   = ST_IDLE;
      cnt_d     = '0;
    end else if (w_inc_only) begin
      w_key_hit = 1'b1;
      cnt_d     = '0;
      if (state_q == ST_WIN_INC) begin
        sh_thr_d = thr_add(sh_thr_q, c_fast_step);
        state_d  = ST_IDLE;
      end else begin
        sh_thr_d = thr_add(sh_thr_q, c_fine_step);
        state_d  = ST_WIN_INC;
      end
    end else if (w_dec_only) begin
      w_key_hit = 1'b1;
      cnt_d     = '0;
      if (state_q == ST_WIN_DEC) begin
        sh_thr_d = thr_sub(sh_thr_q, c_fast_step);
        state_d  = ST_IDLE;
      end else begin
        sh_thr_d = thr_sub(sh_thr_q, c_fine_step);
        state_d  = ST_WIN_DEC;
      end
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == c_win_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // A key landing in the commit cycle re-arms dirty so its value goes out next frame.
  always_comb begin
    dirty_d = dirty_q;
    if (w_key_hit)     dirty_d = 1'b1;
    else if (w_commit) dirty_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sh_mode_q      <= '0;
      sh_thr_q       <= c_thr_init;
      dirty_q        <= 1'b0;
      vs_q           <= 1'b0;
      proc_mode_q    <= '0;
      threshold_q    <= c_thr_init;
      param_update_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sh_mode_q      <= sh_mode_d;
      sh_thr_q       <= sh_thr_d;
      dirty_q        <= dirty_d;
      vs_q           <= frame_vsync;
      param_update_q <= w_commit;
      if (w_commit) begin
        proc_mode_q <= sh_mode_q;
        threshold_q <= sh_thr_q;
      end
    end
  end

  assign proc_mode    = proc_mode_q;
  assign threshold    = threshold_q;
  assign param_update = param_update_q;

endmodule

`default_nettype wire

// File: tb/tb_image_param_ctrl.sv
// tb_image_param_ctrl: directed self-checking bench for image_param_ctrl (short double-press window).
`default_nettype none

module tb_image_param_ctrl;

  localparam int WIN = 1200;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_mode, key_inc, key_dec, frame_vsync;
  logic [1:0] proc_mode;
  logic [7:0] threshold;
  logic       param_update;

  int checks = 0;
  int passed = 0;
  int exp_thr;

  image_param_ctrl #(
    .MODE_NUM  (4),
    .THR_INIT  (128),
    .THR_STEP  (8),
    .FAST_STEP (32),
    .DBL_WINDOW(WIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_mode    (key_mode),
    .key_inc     (key_inc),
    .key_dec     (key_dec),
    .frame_vsync (frame_vsync),
    .proc_mode   (proc_mode),
    .threshold   (threshold),
    .param_update(param_update)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse keys for exactly one sampling edge.
  task automatic press(input logic m, input logic i, input logic d);
    key_mode = m; key_inc = i; key_dec = d;
    @(posedge clk); #1;
    key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
  endtask

  // Rising vsync sampled at one edge; outputs are checked right after that edge.
  task automatic frame();
    frame_vsync = 1'b1;
    @(posedge clk); #1;
    frame_vsync = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0; frame_vsync = 1'b0;
    wait_cyc(3);
    chk("reset_mode", proc_mode, 0);
    chk("reset_thr", threshold, 128);
    chk("reset_pu", param_update, 0);
    rst = 1'b0;
    wait_cyc(2);

    // single press, commit 100 cycles later
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(100);
    chk("single_pre_thr", threshold, 128);
    chk("single_pre_pu", param_update, 0);
    frame();
    chk("single_thr", threshold, 136);
    chk("single_pu", param_update, 1);
    wait_cyc(1);
    chk("single_pu_drop", param_update, 0);

    // async reset mid-window clears committed outputs and the press FSM
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(10);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_thr", threshold, 128);
    chk("rst_async_pu", param_update, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cyc(2);
    press(1'b0, 1'b1, 1'b0);
    frame();
    chk("rst_fine_after", threshold, 136);
    wait_cyc(WIN + 100);

    // double press inside window: +8 then +32
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(999);
    press(1'b0, 1'b1, 1'b0);
    frame();
    chk("double_thr", threshold, 176);
    chk("double_pu", param_update, 1);

    // second press after window expiry: two fine steps
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(WIN + 4);
    press(1'b0, 1'b1, 1'b0);
    frame();
    chk("timeout_thr", threshold, 192);
    wait_cyc(WIN + 100);

    // last cycle of window still counts as double
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(WIN - 1);
    press(1'b0, 1'b1, 1'b0);
    frame();
    chk("win_edge_in", threshold, 232);

    // one cycle later is outside
    press(1'b0, 1'b0, 1'b1);
    wait_cyc(WIN);
    press(1'b0, 1'b0, 1'b1);
    frame();
    chk("win_edge_out", threshold, 216);
    wait_cyc(WIN + 100);

    // 20 fine increments: 216 + 160
    for (int k = 0; k < 20; k++) begin
      press(1'b0, 1'b1, 1'b0);
      wait_cyc(WIN + 5);
    end
    frame();
`ifdef IMAGE_PARAM_WRAP_EN
    exp_thr = 120;
`else
    exp_thr = 255;
`endif
    chk("sat_high", threshold, exp_thr);

    // 7 fine+coarse decrement pairs: -280
    for (int k = 0; k < 7; k++) begin
      press(1'b0, 1'b0, 1'b1);
      wait_cyc(3);
      press(1'b0, 1'b0, 1'b1);
      wait_cyc(3);
    end
    frame();
`ifdef IMAGE_PARAM_WRAP_EN
    exp_thr = 96;
`else
    exp_thr = 0;
`endif
    chk("sat_low", threshold, exp_thr);
    wait_cyc(2);

    // key_mode wins over key_inc
    press(1'b1, 1'b1, 1'b0);
    frame();
    chk("prio_mode", proc_mode, 1);
    chk("prio_thr", threshold, exp_thr);
    wait_cyc(2);

    // mode wraps 1 -> 2 -> 3 -> 0
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, 1'b0);
    frame();
    chk("mode_wrap", proc_mode, 0);
    wait_cyc(2);
    for (int k = 0; k < 4; k++) press(1'b1, 1'b0, 1'b0);
    frame();
    chk("mode_x4", proc_mode, 0);
    chk("mode_x4_pu", param_update, 1);
    wait_cyc(2);

    // inc+dec together are dropped: nothing to commit
    press(1'b0, 1'b1, 1'b1);
    frame();
    chk("incdec_pu", param_update, 0);
    chk("incdec_thr", threshold, exp_thr);
    wait_cyc(2);

    // clean frame without changes
    frame();
    chk("noch_pu", param_update, 0);
    wait_cyc(2);

    // key_dec in the edge cycle: old shadow commits now, new one next frame
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(2);
    frame_vsync = 1'b1; key_dec = 1'b1;
    @(posedge clk); #1;
    key_dec = 1'b0;
    chk("coll_thr", threshold, exp_thr + 8);
    chk("coll_pu", param_update, 1);

    // vsync still high: no new edge, no commit
    wait_cyc(5);
    chk("held_pu", param_update, 0);
    chk("held_thr", threshold, exp_thr + 8);
    frame_vsync = 1'b0;
    wait_cyc(2);
    frame();
    chk("coll_next_thr", threshold, exp_thr);
    chk("coll_next_pu", param_update, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
